// File: rtl/lsu_ctrl_if.sv
// EXU/WBU/dcache-facing bundle of the load/store unit.
// master = environment (EXU, WBU, dcache), slave = lsu_ctrl.
interface lsu_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_store;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [4:0]        in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic [4:0]        out_rd;
  logic              out_excp;
  logic [3:0]        out_cause;

  logic              dc_r_ren;
  logic [ADDR_W-1:0] dc_raddr;
  logic              dc_r_wen;
  logic [ADDR_W-1:0] dc_waddr;
  logic [XLEN-1:0]   dc_wdata;
  logic [7:0]        dc_wmask;
  logic              dc_use_cache;
  logic              dc_inst_update;
  logic [XLEN-1:0]   dc_rdata_align;
  logic              dc_cache_finish;

  modport master (
    output in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_rdata, out_rd, out_excp, out_cause,
    output out_ready,
    input  dc_r_ren, dc_raddr, dc_r_wen, dc_waddr, dc_wdata, dc_wmask,
    input  dc_use_cache, dc_inst_update,
    output dc_rdata_align, dc_cache_finish
  );

  modport slave (
    input  in_valid, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_rdata, out_rd, out_excp, out_cause,
    input  out_ready,
    output dc_r_ren, dc_raddr, dc_r_wen, dc_waddr, dc_wdata, dc_wmask,
    output dc_use_cache, dc_inst_update,
    input  dc_rdata_align, dc_cache_finish
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one op in flight, dcache request held until cache_finish, extended result to WBU.
// Optional LSU_MISALIGN_TRAP_EN: misaligned/illegal ops trap in IDLE without touching the dcache.
module lsu_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

  // state | meaning
  // IDLE  | in_ready=1, waiting for an op from EXU
  // REQ   | dcache request asserted from latched op, waiting for dc_cache_finish
  // RESP  | out_valid=1, result held until WBU takes it
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [7:0]        wmask_q;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_rdata_q;
  logic [4:0]        out_rd_q;
  logic              out_excp_q;
  logic [3:0]        out_cause_q;
  logic              r_ren_q;
  logic              r_wen_q;
  logic              use_cache_q;
  logic              inst_update_q;

  logic              misaligned;

  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // funct3=111 falls into the 64-bit arm, i.e. behaves as ld
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'b000:  extend = {{(XLEN-8){d[7]}},   d[7:0]};
      3'b001:  extend = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b010:  extend = {{(XLEN-32){d[31]}}, d[31:0]};
      3'b100:  extend = {{(XLEN-8){1'b0}},   d[7:0]};
      3'b101:  extend = {{(XLEN-16){1'b0}},  d[15:0]};
      3'b110:  extend = {{(XLEN-32){1'b0}},  d[31:0]};
      default: extend = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.in_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = bus.in_addr[0];
      3'b010, 3'b110: misaligned = |bus.in_addr[1:0];
      3'b011:         misaligned = |bus.in_addr[2:0];
      default:        misaligned = 1'b1;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      wmask_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_rdata_q   <= '0;
      out_rd_q      <= '0;
      out_excp_q    <= 1'b0;
      out_cause_q   <= '0;
      r_ren_q       <= 1'b0;
      r_wen_q       <= 1'b0;
      use_cache_q   <= 1'b0;
      inst_update_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            is_store_q <= bus.in_is_store;
            funct3_q   <= bus.in_funct3;
            addr_q     <= bus.in_addr;
            wdata_q    <= bus.in_wdata;
            rd_q       <= bus.in_rd;
            wmask_q    <= size_mask(bus.in_funct3);
            in_ready_q <= 1'b0;
            if (misaligned) begin
              state       <= RESP;
              out_valid_q <= 1'b1;
              out_rdata_q <= '0;
              out_rd_q    <= bus.in_rd;
              out_excp_q  <= 1'b1;
              out_cause_q <= bus.in_is_store ? 4'd6 : 4'd4;
            end else begin
              state         <= REQ;
              r_ren_q       <= ~bus.in_is_store;
              r_wen_q       <= bus.in_is_store;
              use_cache_q   <= 1'b1;
              inst_update_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // request drops at the finish edge so the dcache never sees a second trigger
          if (bus.dc_cache_finish) begin
            state         <= RESP;
            r_ren_q       <= 1'b0;
            r_wen_q       <= 1'b0;
            use_cache_q   <= 1'b0;
            inst_update_q <= 1'b0;
            out_valid_q   <= 1'b1;
            out_rdata_q   <= is_store_q ? '0 : extend(funct3_q, bus.dc_rdata_align);
            out_rd_q      <= rd_q;
            out_excp_q    <= 1'b0;
            out_cause_q   <= '0;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_rdata      = out_rdata_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_excp       = out_excp_q;
  assign bus.out_cause      = out_cause_q;
  assign bus.dc_r_ren       = r_ren_q;
  assign bus.dc_r_wen       = r_wen_q;
  assign bus.dc_raddr       = addr_q;
  assign bus.dc_waddr       = addr_q;
  assign bus.dc_wdata       = wdata_q;
  assign bus.dc_wmask       = wmask_q;
  assign bus.dc_use_cache   = use_cache_q;
  assign bus.dc_inst_update = inst_update_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; the dcache side is driven by hand from the main sequence.
// Define LSU_MISALIGN_TRAP_EN on both files to exercise the trap build.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   t_acc = 0;

  lsu_ctrl_if #(.XLEN(64), .ADDR_W(32)) bus ();

  lsu_ctrl #(.XLEN(64), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op in the cycle after the current edge; returns just after the accept edge
  // with the EXU inputs scrambled so any leak through from them shows up on the dcache side.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [63:0] wd, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_is_store = st;
    bus.in_funct3   = f3;
    bus.in_addr     = a;
    bus.in_wdata    = wd;
    bus.in_rd       = rd;
    @(negedge clk);
    chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_is_store = ~st;
    bus.in_funct3   = 3'b011;
    bus.in_addr     = 32'hDEAD_BEEF;
    bus.in_wdata    = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.in_rd       = 5'd31;
  endtask

  // Finish pulse is high in the n-th cycle after REQ entry (n=0: first REQ cycle).
  task automatic finish_at(input int n, input logic [63:0] data);
    repeat (n) begin @(posedge clk); #1; end
    bus.dc_cache_finish = 1'b1;
    bus.dc_rdata_align  = data;
    @(posedge clk); #1;
    bus.dc_cache_finish = 1'b0;
    bus.dc_rdata_align  = 64'h0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ovalid_low"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_iready_high"}, {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] data, input logic [63:0] exp, input logic [4:0] rd);
    send(1'b0, f3, a, 64'h0, rd);
    finish_at(1, data);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, "_rdata"}, bus.out_rdata, exp);
    chk({tag, "_rd"}, {59'd0, bus.out_rd}, {59'd0, rd});
    chk({tag, "_excp"}, {63'd0, bus.out_excp}, 64'd0);
    drain(tag);
  endtask

  initial begin
    logic [63:0] held;
    int          t_ov;
    bit          seen;

    bus.in_valid        = 1'b0;
    bus.in_is_store     = 1'b0;
    bus.in_funct3       = 3'b000;
    bus.in_addr         = 32'h0;
    bus.in_wdata        = 64'h0;
    bus.in_rd           = 5'd0;
    bus.out_ready       = 1'b0;
    bus.dc_rdata_align  = 64'h0;
    bus.dc_cache_finish = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   {63'd0, bus.in_ready},       64'd1);
    chk("rst_out_valid",  {63'd0, bus.out_valid},      64'd0);
    chk("rst_inst_upd",   {63'd0, bus.dc_inst_update}, 64'd0);
    chk("rst_ren_wen",    {62'd0, bus.dc_r_ren, bus.dc_r_wen}, 64'd0);
    @(posedge clk); #1;

    // sb 0x1FF to 0x80000003
    send(1'b1, 3'b000, 32'h8000_0003, 64'h1FF, 5'd7);
    @(negedge clk);
    chk("sb_wen",    {63'd0, bus.dc_r_wen},       64'd1);
    chk("sb_ren",    {63'd0, bus.dc_r_ren},       64'd0);
    chk("sb_wmask",  {56'd0, bus.dc_wmask},       64'h01);
    chk("sb_wdata",  bus.dc_wdata,                64'h1FF);
    chk("sb_upd",    {63'd0, bus.dc_inst_update}, 64'd1);
    chk("sb_usec",   {63'd0, bus.dc_use_cache},   64'd1);
    chk("sb_iready", {63'd0, bus.in_ready},       64'd0);
    @(negedge clk);
    chk("sb_waddr_held", {32'd0, bus.dc_waddr},   64'h8000_0003);
    finish_at(3, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("sb_upd_drop", {63'd0, bus.dc_inst_update}, 64'd0);
    chk("sb_wen_drop", {63'd0, bus.dc_r_wen},       64'd0);
    chk("sb_ovalid",   {63'd0, bus.out_valid},      64'd1);
    chk("sb_rdata",    bus.out_rdata,               64'h0);
    drain("sb");

    do_load("lb",  3'b000, 32'h8000_0003, 64'h1234_5678_9ABC_DEFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    do_load("lbu", 3'b100, 32'h8000_0003, 64'h1234_5678_9ABC_DEFF, 64'h0000_0000_0000_00FF, 5'd2);
    do_load("lh",  3'b001, 32'h8000_0002, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001, 5'd3);
    do_load("lhu", 3'b101, 32'h8000_0002, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_8001, 5'd4);
    do_load("lw",  3'b010, 32'h8000_0004, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 5'd5);
    do_load("lwu", 3'b110, 32'h8000_0004, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 5'd6);
    do_load("ld",  3'b011, 32'h8000_0008, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9, 5'd8);
`ifndef LSU_MISALIGN_TRAP_EN
    do_load("f111", 3'b111, 32'h8000_0008, 64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001, 5'd9);
`endif

    // lw hit, finish two cycles after REQ entry, then WBU stalls
    send(1'b0, 3'b010, 32'h8000_0010, 64'h0, 5'd10);
    finish_at(2, 64'h0000_0000_8765_4321);
    seen = 1'b0;
    t_ov = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; t_ov = cyc; end
    end
    chk("lat_seen", {63'd0, seen}, 64'd1);
    chk("lat_cycles", 64'(t_ov - t_acc), 64'd4);
    held = 64'hFFFF_FFFF_8765_4321;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.dc_cache_finish = 1'b1;
      @(negedge clk);
      bus.dc_cache_finish = 1'b0;
      chk("hold_valid",  {63'd0, bus.out_valid}, 64'd1);
      chk("hold_rdata",  bus.out_rdata, held);
      chk("hold_rd",     {59'd0, bus.out_rd}, 64'd10);
      chk("hold_iready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid = 1'b0;
    drain("hold");
    @(negedge clk);
    chk("ign_inval_upd", {63'd0, bus.dc_inst_update}, 64'd0);

    // stray finish while idle must not start anything
    bus.dc_cache_finish = 1'b1;
    @(posedge clk); #1;
    bus.dc_cache_finish = 1'b0;
    @(negedge clk);
    chk("stray_fin_ovalid", {63'd0, bus.out_valid}, 64'd0);
    chk("stray_fin_iready", {63'd0, bus.in_ready},  64'd1);
    @(posedge clk); #1;

    // reset during a dcache miss
    send(1'b0, 3'b011, 32'h8000_0020, 64'h0, 5'd11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_iready", {63'd0, bus.in_ready},       64'd1);
    chk("mid_rst_upd",    {63'd0, bus.dc_inst_update}, 64'd0);
    chk("mid_rst_ren",    {63'd0, bus.dc_r_ren},       64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_ovalid", {63'd0, seen}, 64'd0);
    @(posedge clk); #1;
    do_load("post_rst_ld", 3'b011, 32'h8000_0020, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 5'd12);

    // lw from a 2-byte-aligned address
    send(1'b0, 3'b010, 32'h8000_0002, 64'h0, 5'd13);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_upd",   {63'd0, bus.dc_inst_update}, 64'd0);
    chk("mis_valid", {63'd0, bus.out_valid},      64'd1);
    chk("mis_excp",  {63'd0, bus.out_excp},       64'd1);
    chk("mis_cause", {60'd0, bus.out_cause},      64'd4);
    chk("mis_rdata", bus.out_rdata,               64'h0);
    @(posedge clk); #1;
    drain("mis");
`else
    chk("mis_upd",   {63'd0, bus.dc_inst_update}, 64'd1);
    chk("mis_raddr", {32'd0, bus.dc_raddr},       64'h8000_0002);
    chk("mis_valid", {63'd0, bus.out_valid},      64'd0);
    finish_at(1, 64'h0000_0000_1111_2222);
    @(negedge clk);
    chk("mis_excp",  {63'd0, bus.out_excp},       64'd0);
    chk("mis_cause", {60'd0, bus.out_cause},      64'd0);
    chk("mis_rdata", bus.out_rdata,               64'h0000_0000_1111_2222);
    drain("mis");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
